memory_loader: RTL and testbench
================================

Name: memory_loader

Overview:
Upstream write sequencer for memory_cell. It accepts a load command (base address and word count), then takes words from a valid/ready stream. Each accepted word is turned into a registered write strobe, address and data that drive memory_cell's write port directly. It is used to fill weight and activation memories from the host/DMA stream before compute starts.

Parameters:
DEPTH, 2, number of words in the target memory_cell; must be >= 2 (DEPTH=1 unsupported)
BIT_SIZE, 16, data word width; matches memory_cell BIT_SIZE
AW (localparam), $clog2(DEPTH), address width
LW (localparam), $clog2(DEPTH)+1, length width; holds 0..DEPTH

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous, active-low reset
start  in  1  command strobe; sampled only in IDLE
base_addr  in  AW  first write address, sampled with start
length  in  LW  words to load, sampled with start; values > DEPTH are clamped to DEPTH
in_valid  in  1  stream word valid
in_data  in  BIT_SIZE  stream word
in_ready  out  1  loader accepts a word this cycle
mem_write_enable  out  1  to memory_cell write_enable
mem_addr  out  AW  to memory_cell addr
mem_data_in  out  BIT_SIZE  to memory_cell data_in
busy  out  1  command in progress
done  out  1  one-cycle pulse: all writes of the command committed

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rst_n.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; all outputs 0; internal address and remaining counters 0.
  - A reset mid-command abandons the command and drops mem_write_enable at the same edge, so no further writes occur.
- States:
  - IDLE: in_ready=0, busy=0.
    - start=1 with clamped length>0: latch addr_cnt=base_addr, remaining=length; go to LOAD.
    - start=1 with length=0: go to DONE (no writes).
  - LOAD: in_ready=1, busy=1.
    - Transfer occurs when in_valid && in_ready at a rising edge. At that edge:
      - mem_write_enable<=1, mem_addr<=addr_cnt, mem_data_in<=in_data
      - addr_cnt<=(addr_cnt==DEPTH-1) ? 0 : addr_cnt+1 (wraps; no error)
      - remaining<=remaining-1
    - No transfer at the edge: mem_write_enable<=0.
    - A transfer with remaining==1 moves to DRAIN.
  - DRAIN: in_ready=0, busy=1. The last write strobe is on the port this cycle and memory_cell commits it at the next edge. Then go to DONE with mem_write_enable<=0.
  - DONE: done=1 for exactly one cycle, busy=0, in_ready=0. Then go to IDLE. start is ignored in DONE.
- Latency and timing:
  - Word accepted at edge N: strobe is visible during cycle N..N+1 and data is in memory after edge N+1.
  - done rises one cycle after the last strobe.
  - Back-to-back acceptance gives one write per cycle.
- Other rules:
  - start is ignored while in LOAD, DRAIN or DONE.
  - in_valid gaps produce gaps in mem_write_enable only; address and count do not advance.
  - in_data is ignored when in_ready=0.
  - Address arithmetic is modulo DEPTH, correct for non-power-of-two DEPTH.
  - length clamp: a value above DEPTH is treated as DEPTH.
- All outputs are registered or decoded from the state register only; there is no combinational path from input to output.

Decomposition:
- Package nn_mem_pkg holds:
  - loader state enum (IDLE, LOAD, DRAIN, DONE)
  - default BIT_SIZE
  - wrap-increment function next_addr(addr, DEPTH), shared with the future read sequencer
- No sub-module. memory_cell is instantiated beside the loader at the top level, not inside it.

Test Plan:
- Basic fill: DEPTH=4; start, base=0, len=4; words 0xA0..0xA3 streamed with no gaps. Expect strobes at addr 0,1,2,3, done 1 cycle after the last strobe, memory readback A0,A1,A2,A3.
- Wrap-around: DEPTH=4; base=3, len=3, data 0x11,0x22,0x33. Expect writes at addr 3,0,1; addr 2 keeps its prior value.
- Bubbles: len=2 with in_valid pattern 1,0,0,1. Expect exactly 2 strobes separated by 2 idle cycles, and in_ready high throughout LOAD.
- Zero and oversize length: len=0 gives done on the 2nd cycle after start with no strobe. len=7 with DEPTH=4 gives exactly 4 writes.
- Start while busy: a second start mid-LOAD with base=2 is ignored. The original address sequence continues and only one done pulse appears.
- Reset mid-operation: rst_n=0 after 1 of 3 words. At the next edge, mem_write_enable, busy and in_ready are 0. Memory holds only word 1, and a new start then loads normally.

Source files
------------

// File: rtl/nn_mem_pkg.sv
// Shared definitions for the neural-net memory sequencers: loader state
// encoding, default word width and modulo-DEPTH address increment.
package nn_mem_pkg;

    localparam int DEFAULT_BIT_SIZE = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } loader_state_t;

    // Wraps to 0 after depth-1, so non-power-of-two depths stay in range.
    function automatic int unsigned next_addr(input int unsigned addr, input int unsigned depth);
        return (addr == depth - 1) ? 0 : addr + 1;
    endfunction

endpackage

// File: rtl/memory_loader.sv
// Write sequencer for memory_cell: latches a (base, length) command, then turns
// each accepted stream word into a registered write strobe, address and data.
module memory_loader
    import nn_mem_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int BIT_SIZE = DEFAULT_BIT_SIZE
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [$clog2(DEPTH)-1:0]  base_addr,
    input  logic [$clog2(DEPTH):0]    length,
    input  logic                      in_valid,
    input  logic [BIT_SIZE-1:0]       in_data,
    output logic                      in_ready,
    output logic                      mem_write_enable,
    output logic [$clog2(DEPTH)-1:0]  mem_addr,
    output logic [BIT_SIZE-1:0]       mem_data_in,
    output logic                      busy,
    output logic                      done
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_LOAD  = 2'(LOAD);
    localparam logic [1:0] ST_DRAIN = 2'(DRAIN);
    localparam logic [1:0] ST_DONE  = 2'(DONE);

    // Stream handshake: a word transfers at a rising edge where in_valid and
    // in_ready are both high; in_ready depends only on state, never on in_valid.

    logic [1:0]    state;
    logic [AW-1:0] addr_cnt;
    logic [LW-1:0] remaining;
    logic [LW-1:0] len_clamped;

    assign len_clamped = (length > LW'(DEPTH)) ? LW'(DEPTH) : length;

    assign in_ready = (state == ST_LOAD);
    assign busy     = (state == ST_LOAD) || (state == ST_DRAIN);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            addr_cnt         <= '0;
            remaining        <= '0;
            mem_write_enable <= 1'b0;
            mem_addr         <= '0;
            mem_data_in      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    mem_write_enable <= 1'b0;
                    if (start) begin
                        if (len_clamped == '0) begin
                            state <= ST_DONE;
                        end else begin
                            addr_cnt  <= base_addr;
                            remaining <= len_clamped;
                            state     <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_valid) begin
                        mem_write_enable <= 1'b1;
                        mem_addr         <= addr_cnt;
                        mem_data_in      <= in_data;
                        addr_cnt         <= AW'(next_addr(32'(addr_cnt), 32'(DEPTH)));
                        remaining        <= remaining - LW'(1);
                        if (remaining == LW'(1)) begin
                            state <= ST_DRAIN;
                        end
                    end else begin
                        mem_write_enable <= 1'b0;
                    end
                end
                // Last strobe is on the port this cycle; memory_cell commits it now.
                ST_DRAIN: begin
                    mem_write_enable <= 1'b0;
                    state            <= ST_DONE;
                end
                default: begin
                    mem_write_enable <= 1'b0;
                    state            <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_loader.sv
// Directed bench for memory_loader with DEPTH=4: strobe log, memory_cell model
// and hand-computed expected write sequences.
module tb_memory_loader;

    localparam int DEPTH = 4;
    localparam int BW    = 16;
    localparam int AW    = 2;
    localparam int LW    = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] length;
    logic          in_valid;
    logic [BW-1:0] in_data;
    logic          in_ready;
    logic          mem_write_enable;
    logic [AW-1:0] mem_addr;
    logic [BW-1:0] mem_data_in;
    logic          busy;
    logic          done;

    memory_loader #(.DEPTH(DEPTH), .BIT_SIZE(BW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .base_addr        (base_addr),
        .length           (length),
        .in_valid         (in_valid),
        .in_data          (in_data),
        .in_ready         (in_ready),
        .mem_write_enable (mem_write_enable),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_cnt = 0;

    logic [BW-1:0]    mem_model [DEPTH];
    logic [AW+BW-1:0] obs_q [$];
    int               obs_cyc [$];
    logic [AW+BW-1:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: memory model commits pre-edge strobe, then outputs sampled 1ns after edge.
    task automatic tick();
        logic          we;
        logic [AW-1:0] a;
        logic [BW-1:0] d;
        we = mem_write_enable;
        a  = mem_addr;
        d  = mem_data_in;
        @(posedge clk);
        if (we) mem_model[a] = d;
        cyc++;
        #1;
        if (mem_write_enable) begin
            obs_q.push_back({mem_addr, mem_data_in});
            obs_cyc.push_back(cyc);
        end
        if (done) done_cnt++;
    endtask

    task automatic send_cmd(input logic [AW-1:0] b, input logic [LW-1:0] l);
        start     = 1'b1;
        base_addr = b;
        length    = l;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_word(input logic [BW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [BW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic check_writes(input string tag);
        logic [AW+BW-1:0] o;
        logic [AW+BW-1:0] e;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_write"}, 32'(o), 32'(e));
        end
        exp_q.delete();
        obs_q.delete();
        obs_cyc.delete();
    endtask

    task automatic wait_done(input string tag, input int max_cyc, input int exp_lat);
        int n;
        n = 0;
        while (!done && n < max_cyc) begin
            tick();
            n++;
        end
        if (!done) check({tag, "_done_timeout"}, 32'(n), 32'(max_cyc + 1));
        else       check({tag, "_done_lat"}, 32'(n), 32'(exp_lat));
    endtask

    int d0;
    int gap;

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        length    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_we", 32'(mem_write_enable), 0);
        check("rst_addr_data", 32'({mem_addr, mem_data_in}), 0);
        rst_n = 1'b1;
        tick();
        obs_q.delete();
        obs_cyc.delete();

        // Basic fill
        send_cmd(2'd0, 3'd4);
        check("fill_busy", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            check("fill_ready", 32'(in_ready), 1);
            send_word(16'hA0 + 16'(i));
        end
        wait_done("fill", 10, 1);
        check("fill_done_busy", 32'(busy), 0);
        tick();
        check("fill_done_pulse", 32'(done), 0);
        for (int i = 0; i < 4; i++) expect_write(AW'(i), 16'hA0 + 16'(i));
        check_writes("fill");
        for (int i = 0; i < 4; i++) check("fill_mem", 32'(mem_model[i]), 32'(16'hA0 + 16'(i)));

        // Wrap-around
        send_cmd(2'd3, 3'd3);
        send_word(16'h11);
        send_word(16'h22);
        send_word(16'h33);
        wait_done("wrap", 10, 1);
        tick();
        expect_write(2'd3, 16'h11);
        expect_write(2'd0, 16'h22);
        expect_write(2'd1, 16'h33);
        check_writes("wrap");
        check("wrap_mem0", 32'(mem_model[0]), 32'h22);
        check("wrap_mem2_kept", 32'(mem_model[2]), 32'hA2);
        check("wrap_mem3", 32'(mem_model[3]), 32'h11);

        // Bubbles: valid pattern 1,0,0,1 with junk data during gaps
        send_cmd(2'd0, 3'd2);
        check("bub_ready0", 32'(in_ready), 1);
        send_word(16'h55);
        for (int i = 0; i < 2; i++) begin
            check("bub_ready_gap", 32'(in_ready), 1);
            in_data = 16'hDEAD;
            tick();
        end
        check("bub_ready3", 32'(in_ready), 1);
        send_word(16'h66);
        check("bub_ready_drain", 32'(in_ready), 0);
        if (obs_cyc.size() == 2) gap = obs_cyc[1] - obs_cyc[0];
        else gap = -1;
        check("bub_gap", 32'(gap), 3);
        wait_done("bub", 10, 1);
        tick();
        expect_write(2'd0, 16'h55);
        expect_write(2'd1, 16'h66);
        check_writes("bub");

        // Zero length: done right after the start edge, no strobe
        send_cmd(2'd1, 3'd0);
        check("zero_done", 32'(done), 1);
        check("zero_busy", 32'(busy), 0);
        tick();
        check("zero_done_end", 32'(done), 0);
        check_writes("zero");

        // Oversize length clamps to DEPTH
        d0 = done_cnt;
        send_cmd(2'd1, 3'd7);
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 16'h70 + 16'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        check("over_done_cnt", 32'(done_cnt - d0), 1);
        expect_write(2'd1, 16'h70);
        expect_write(2'd2, 16'h71);
        expect_write(2'd3, 16'h72);
        expect_write(2'd0, 16'h73);
        check_writes("over");

        // Start while busy is ignored
        d0 = done_cnt;
        send_cmd(2'd0, 3'd3);
        send_word(16'h91);
        start     = 1'b1;
        base_addr = 2'd2;
        length    = 3'd1;
        send_word(16'h92);
        start = 1'b0;
        send_word(16'h93);
        wait_done("busy_start", 10, 1);
        repeat (3) tick();
        check("busy_start_done_cnt", 32'(done_cnt - d0), 1);
        expect_write(2'd0, 16'h91);
        expect_write(2'd1, 16'h92);
        expect_write(2'd2, 16'h93);
        check_writes("busy_start");

        // Reset after the first of three words
        send_cmd(2'd2, 3'd3);
        send_word(16'hC1);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'hC2;
        tick();
        check("mrst_we", 32'(mem_write_enable), 0);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_ready", 32'(in_ready), 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (2) tick();
        check("mrst_mem2", 32'(mem_model[2]), 32'hC1);
        check("mrst_mem3_kept", 32'(mem_model[3]), 32'h72);
        expect_write(2'd2, 16'hC1);
        check_writes("mrst");
        send_cmd(2'd0, 3'd2);
        send_word(16'hE1);
        send_word(16'hE2);
        wait_done("post_rst", 10, 1);
        tick();
        expect_write(2'd0, 16'hE1);
        expect_write(2'd1, 16'hE2);
        check_writes("post_rst");
        check("post_rst_mem0", 32'(mem_model[0]), 32'hE1);
        check("post_rst_mem1", 32'(mem_model[1]), 32'hE2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
